nx_stream_distributor: RTL
==========================

Name: nx_stream_distributor

Overview:
- Downstream stage of the stream combiner. Consumes one arbitrated directed stream (data plus 2-bit direction) and routes each message to one of four outbound streams: north, east, south, west.
- Each direction has its own buffer, so a stalled consumer only blocks traffic headed its way.
- Sits between the node's combined message path and the four neighbour links of the mesh.

Parameters:
- STREAM_WIDTH, 32, width of message data in bits.
- FIFO_DEPTH, 2, entries per outbound buffer. Legal range is 1 to 16; any value is allowed, not only powers of 2.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; asynchronous assert, active-low (0 = in reset); released synchronously outside the block.
- inbound_data_i  input  STREAM_WIDTH  inbound message.
- inbound_dir_i  input  2  target direction: 0=N, 1=E, 2=S, 3=W.
- inbound_valid_i  input  1  inbound message present.
- inbound_ready_o  output  1  inbound message accepted this cycle when high with valid.
- north_data_o, east_data_o, south_data_o, west_data_o  output  STREAM_WIDTH each  head entry of each direction's buffer.
- north_valid_o, east_valid_o, south_valid_o, west_valid_o  output  1 each  buffer non-empty.
- north_ready_i, east_ready_i, south_ready_i, west_ready_i  input  1 each  consumer accepts head entry.
- idle_o  output  1  all four buffers empty and inbound_valid_i low.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All buffer pointers and counts clear.
  - All *_valid_o = 0, so idle_o follows !inbound_valid_i; inbound_ready_o = 1.
  - *_data_o = 0.
  - Buffer contents are discarded when reset is asserted mid-operation.
- Inbound handshake:
  - inbound_ready_o = !full[inbound_dir_i], combinational on the direction only. There is no path from any *_ready_i to inbound_ready_o.
  - Transfer happens when inbound_valid_i && inbound_ready_o. The message is written to the buffer selected by inbound_dir_i.
  - The upstream may change dir/data while valid is high and ready is low. The distributor holds no state for an unaccepted message.
- Latency: a message accepted in cycle N is visible on the target *_data_o/*_valid_o in cycle N+1. There is no combinational pass-through.
- Outbound handshake, per direction:
  - valid = count != 0.
  - A pop occurs when valid && ready. The next entry, if any, is presented in the following cycle.
  - Data stays stable while valid is high and ready is low.
- Ordering: FIFO order is strictly preserved per direction. No ordering is guaranteed across directions.
- Buffers:
  - Circular read and write pointers of width clog2(FIFO_DEPTH), minimum 1 bit.
  - Pointers wrap at FIFO_DEPTH-1 back to 0; this explicit compare is required for non-power-of-2 depths.
  - Count is clog2(FIFO_DEPTH+1) bits. full = count == FIFO_DEPTH; empty = count == 0.
- Simultaneous push and pop on the same direction:
  - Count is unchanged and both pointers advance.
  - When full, no push is allowed in that cycle even if a pop is occurring. Inbound ready stays low for that cycle; this is a deliberate choice to break the ready chain.
- Simultaneous pops on multiple directions are independent.
- Directions not selected by inbound_dir_i never affect inbound_ready_o.
- idle_o is combinational. Verification and power-gating logic use it.
- Invalid conditions:
  - inbound_dir_i is always one of 0 to 3; no illegal encoding exists.
  - X on inbound_dir_i while valid is high is a protocol violation. The bench asserts this never occurs.

Test Plan:
- Routing and latency: reset, then drive 4 messages in consecutive cycles with data 0x11,0x22,0x33,0x44 and dir 0,1,2,3, all outbound ready=1 -> each appears on N/E/S/W respectively exactly one cycle after acceptance; inbound_ready_o stays 1 throughout.
- Backpressure and full: FIFO_DEPTH=2, east_ready_i=0, send 3 messages with dir=1 (0xA0,0xA1,0xA2) -> first two accepted, inbound_ready_o=0 while dir=1 and the third is held. Then raise east_ready_i -> east outputs 0xA0,0xA1,0xA2 in order; ready returns 1 the cycle after the first pop.
- Head-of-line isolation: east full and stalled, then send dir=2 data 0x55 -> accepted immediately and south_valid_o=1 next cycle; east contents untouched.
- Full with concurrent pop: north full, north_ready_i=1 and inbound dir=0 in the same cycle -> pop occurs, push refused that cycle, accepted the next cycle; order preserved.
- Wrap-around: FIFO_DEPTH=3, 10 messages 0..9 to west with west_ready_i toggling 1,0,1,0 -> all 10 delivered in order, count never exceeds 3, no loss or duplication.
- Mid-operation reset: 2 messages buffered in north and 1 in south, drive rst_i low asynchronously mid-cycle -> all *_valid_o drop immediately. After release, idle_o=1 with inbound_valid_i=0, and the next message routes correctly.

Source files
------------

// File: rtl/nx_stream_distributor.sv
// Routes one directed inbound stream into four independently buffered
// outbound streams (N/E/S/W); a stalled consumer only blocks its own direction.
module nx_stream_distributor #(
  parameter int unsigned STREAM_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [STREAM_WIDTH-1:0] inbound_data_i,
  input  logic [1:0]              inbound_dir_i,
  input  logic                    inbound_valid_i,
  output logic                    inbound_ready_o,
  output logic [STREAM_WIDTH-1:0] north_data_o,
  output logic [STREAM_WIDTH-1:0] east_data_o,
  output logic [STREAM_WIDTH-1:0] south_data_o,
  output logic [STREAM_WIDTH-1:0] west_data_o,
  output logic                    north_valid_o,
  output logic                    east_valid_o,
  output logic                    south_valid_o,
  output logic                    west_valid_o,
  input  logic                    north_ready_i,
  input  logic                    east_ready_i,
  input  logic                    south_ready_i,
  input  logic                    west_ready_i,
  output logic                    idle_o
);
  localparam int unsigned NUM_DIR   = 4;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MEM_DEPTH = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [STREAM_WIDTH-1:0] mem_q    [NUM_DIR][MEM_DEPTH];
  logic [STREAM_WIDTH-1:0] mem_d    [NUM_DIR][MEM_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q [NUM_DIR];
  logic [PTR_W-1:0]        wr_ptr_d [NUM_DIR];
  logic [PTR_W-1:0]        rd_ptr_q [NUM_DIR];
  logic [PTR_W-1:0]        rd_ptr_d [NUM_DIR];
  logic [CNT_W-1:0]        cnt_q    [NUM_DIR];
  logic [CNT_W-1:0]        cnt_d    [NUM_DIR];
  logic [STREAM_WIDTH-1:0] head_c   [NUM_DIR];
  logic [NUM_DIR-1:0]      out_ready_c;
  logic [NUM_DIR-1:0]      full_c;
  logic [NUM_DIR-1:0]      empty_c;
  logic [NUM_DIR-1:0]      push_c;
  logic [NUM_DIR-1:0]      pop_c;

  // Explicit wrap compare so non-power-of-2 depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_ready_c = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};

  always_comb begin
    full_c  = '0;
    empty_c = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      head_c[i]  = mem_q[i][rd_ptr_q[i]];
      full_c[i]  = (cnt_q[i] == CNT_FULL);
      empty_c[i] = (cnt_q[i] == '0);
    end
  end

  // Ready depends only on the selected buffer's fullness, never on outbound ready.
  assign inbound_ready_o = ~full_c[inbound_dir_i];
  assign idle_o          = (&empty_c) & ~inbound_valid_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_c   = '0;
    pop_c    = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      push_c[i] = inbound_valid_i && !full_c[i] && (inbound_dir_i == 2'(i));
      pop_c[i]  = !empty_c[i] && out_ready_c[i];
      if (push_c[i]) begin
        mem_d[i][wr_ptr_q[i]] = inbound_data_i;
        wr_ptr_d[i]           = ptr_next(wr_ptr_q[i]);
      end
      if (pop_c[i]) begin
        rd_ptr_d[i] = ptr_next(rd_ptr_q[i]);
      end
      case ({push_c[i], pop_c[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        for (int j = 0; j < MEM_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign north_data_o  = head_c[0];
  assign east_data_o   = head_c[1];
  assign south_data_o  = head_c[2];
  assign west_data_o   = head_c[3];
  assign north_valid_o = ~empty_c[0];
  assign east_valid_o  = ~empty_c[1];
  assign south_valid_o = ~empty_c[2];
  assign west_valid_o  = ~empty_c[3];

endmodule
